// File: rtl/wt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_arbiter
// Purpose  : N-port round-robin front end merging L1 client request streams
//            onto a single memory request/return channel. Each request gets
//            a {port, tid} tag, in-flight tags are tracked per port, a per-port
//            outstanding limit is enforced, and returns are routed back to the
//            issuing port.
// Ports    : clk_i, rst_i (async, active-high)
//            req_i/ack_o, addr_i, wdata_i, rtype_i, tid_i : client requests
//            rtrn_vld_o, rtrn_tid_o, rtrn_data_o          : client returns
//            mem_req_o/mem_gnt_i, mem_addr_o, mem_wdata_o,
//            mem_type_o, mem_tag_o                        : memory request
//            mem_rtrn_vld_i, mem_rtrn_tag_i, mem_rtrn_data_i : memory return
//            idle_o : nothing held, nothing in flight
//            err_o  : sticky, a return arrived for a tag not in flight
// Revision : 1.0 - initial release
// ============================================================================
module wt_mem_arbiter #(
   parameter  int NumPorts       = 3,
   parameter  int AddrWidth      = 56,
   parameter  int DataWidth      = 64,
   parameter  int RtrnWidth      = 128,
   parameter  int TidWidth       = 2,
   parameter  int MaxOutstanding = 4,
   localparam int PortW          = (NumPorts > 1) ? $clog2(NumPorts) : 1,
   localparam int TagW           = PortW + TidWidth
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumPorts-1:0]             req_i,
   output logic [NumPorts-1:0]             ack_o,
   input  logic [NumPorts*AddrWidth-1:0]   addr_i,
   input  logic [NumPorts*DataWidth-1:0]   wdata_i,
   input  logic [NumPorts*2-1:0]           rtype_i,
   input  logic [NumPorts*TidWidth-1:0]    tid_i,
   output logic [NumPorts-1:0]             rtrn_vld_o,
   output logic [TidWidth-1:0]             rtrn_tid_o,
   output logic [RtrnWidth-1:0]            rtrn_data_o,
   output logic                            mem_req_o,
   input  logic                            mem_gnt_i,
   output logic [AddrWidth-1:0]            mem_addr_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   output logic [1:0]                      mem_type_o,
   output logic [TagW-1:0]                 mem_tag_o,
   input  logic                            mem_rtrn_vld_i,
   input  logic [TagW-1:0]                 mem_rtrn_tag_i,
   input  logic [RtrnWidth-1:0]            mem_rtrn_data_i,
   output logic                            idle_o,
   output logic                            err_o
);

   localparam int              NumTids   = 2**TidWidth;
   localparam int              CntW      = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] c_max_cnt = CntW'(MaxOutstanding);

   // Tracking state
   logic [NumPorts-1:0][NumTids-1:0] r_busy;
   logic [NumPorts-1:0][CntW-1:0]    r_cnt;
   logic [PortW-1:0]                 r_rr;

   // Output register
   logic                 r_mem_vld;
   logic [AddrWidth-1:0] r_mem_addr;
   logic [DataWidth-1:0] r_mem_wdata;
   logic [1:0]           r_mem_type;
   logic [TagW-1:0]      r_mem_tag;

   // Return path
   logic [NumPorts-1:0]  r_rtrn_vld;
   logic [TidWidth-1:0]  r_rtrn_tid;
   logic [RtrnWidth-1:0] r_rtrn_data;
   logic                 r_err;

   logic                 w_free;
   logic                 w_found;
   logic                 w_acc;
   logic [PortW-1:0]     w_win;
   logic [TidWidth-1:0]  w_win_tid;
   logic [NumPorts-1:0]  w_elig;
   logic [NumPorts-1:0]  w_ack;
   logic [PortW-1:0]     w_rt_port;
   logic [TidWidth-1:0]  w_rt_tid;
   logic [NumPorts-1:0]  w_rt_oh;
   logic                 w_rt_bad;

   // The register can take a new entry when empty or when being drained now.
   assign w_free    = !r_mem_vld || mem_gnt_i;
   assign w_rt_port = mem_rtrn_tag_i[TagW-1:TidWidth];
   assign w_rt_tid  = mem_rtrn_tag_i[TidWidth-1:0];
   assign w_win_tid = tid_i[int'(w_win)*TidWidth +: TidWidth];

   // Eligibility looks only at registered busy/count state; a return in the
   // current cycle frees its slot from the next cycle on.
   always_comb begin : p_elig
      w_elig = '0;
      for (int p = 0; p < NumPorts; p++) begin
         w_elig[p] = req_i[p]
                   && !r_busy[p][tid_i[p*TidWidth +: TidWidth]]
                   && (r_cnt[p] < c_max_cnt);
      end
   end

   // Round-robin search starting at the pointer.
   always_comb begin : p_arb
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NumPorts; i++) begin
         idx = int'(r_rr) + i;
         if (idx >= NumPorts) idx = idx - NumPorts;
         if (!w_found && w_elig[PortW'(idx)]) begin
            w_found = 1'b1;
            w_win   = PortW'(idx);
         end
      end
   end

   // Ack is held low while reset is asserted so outputs show reset values
   // even if clients keep their requests up.
   assign w_acc = w_free && w_found && !rst_i;
   assign w_ack = w_acc ? (NumPorts'(1) << w_win) : '0;
   assign ack_o = w_ack;

   // A return is forwarded only for an in-range port with its busy bit set.
   always_comb begin : p_rtrn_dec
      w_rt_oh = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (mem_rtrn_vld_i && (w_rt_port == PortW'(p)) && r_busy[p][w_rt_tid]) begin
            w_rt_oh[p] = 1'b1;
         end
      end
   end
   assign w_rt_bad = mem_rtrn_vld_i && (w_rt_oh == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin : p_track
      if (rst_i) begin
         r_busy <= '0;
         r_cnt  <= '0;
         r_rr   <= '0;
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            // Accept and return on one port always target different tids.
            if (w_rt_oh[p]) r_busy[p][w_rt_tid] <= 1'b0;
            if (w_ack[p])   r_busy[p][tid_i[p*TidWidth +: TidWidth]] <= 1'b1;
            r_cnt[p] <= r_cnt[p] + CntW'(w_ack[p]) - CntW'(w_rt_oh[p]);
         end
         if (w_acc) begin
            r_rr <= (int'(w_win) == NumPorts - 1) ? '0 : w_win + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : p_outreg
      if (rst_i) begin
         r_mem_vld   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_type  <= '0;
         r_mem_tag   <= '0;
      end else if (w_acc) begin
         r_mem_vld   <= 1'b1;
         r_mem_addr  <= addr_i[int'(w_win)*AddrWidth +: AddrWidth];
         r_mem_wdata <= wdata_i[int'(w_win)*DataWidth +: DataWidth];
         r_mem_type  <= rtype_i[int'(w_win)*2 +: 2];
         r_mem_tag   <= {w_win, w_win_tid};
      end else if (mem_gnt_i) begin
         r_mem_vld   <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : p_return
      if (rst_i) begin
         r_rtrn_vld  <= '0;
         r_rtrn_tid  <= '0;
         r_rtrn_data <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rtrn_vld <= w_rt_oh;
         if (w_rt_oh != '0) begin
            r_rtrn_tid  <= w_rt_tid;
            r_rtrn_data <= mem_rtrn_data_i;
         end
         if (w_rt_bad) r_err <= 1'b1;
      end
   end

   assign mem_req_o   = r_mem_vld;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_type_o  = r_mem_type;
   assign mem_tag_o   = r_mem_tag;
   assign rtrn_vld_o  = r_rtrn_vld;
   assign rtrn_tid_o  = r_rtrn_tid;
   assign rtrn_data_o = r_rtrn_data;
   assign err_o       = r_err;
   assign idle_o      = !r_mem_vld && (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_wt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_mem_arbiter
// Purpose  : Directed self-checking bench for wt_mem_arbiter (3 ports,
//            2-bit tids, per-port limit of 2 in flight).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wt_mem_arbiter;

   localparam int NP = 3;
   localparam int AW = 56;
   localparam int DW = 64;
   localparam int RW = 128;
   localparam int TW = 2;
   localparam int MO = 2;
   localparam int GW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    req;
   logic [NP-1:0]    ack;
   logic [NP*AW-1:0] addr;
   logic [NP*DW-1:0] wdata;
   logic [NP*2-1:0]  rtype;
   logic [NP*TW-1:0] tid;
   logic [NP-1:0]    rtrn_vld;
   logic [TW-1:0]    rtrn_tid;
   logic [RW-1:0]    rtrn_data;
   logic             mem_req;
   logic             gnt;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic [1:0]       mem_type;
   logic [GW-1:0]    mem_tag;
   logic             rv;
   logic [GW-1:0]    rtag;
   logic [RW-1:0]    rdata;
   logic             idle;
   logic             err;

   int total = 0;
   int bad   = 0;

   wt_mem_arbiter #(
      .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .RtrnWidth(RW),
      .TidWidth(TW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_i(req), .ack_o(ack), .addr_i(addr), .wdata_i(wdata),
      .rtype_i(rtype), .tid_i(tid),
      .rtrn_vld_o(rtrn_vld), .rtrn_tid_o(rtrn_tid), .rtrn_data_o(rtrn_data),
      .mem_req_o(mem_req), .mem_gnt_i(gnt), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_type_o(mem_type), .mem_tag_o(mem_tag),
      .mem_rtrn_vld_i(rv), .mem_rtrn_tag_i(rtag), .mem_rtrn_data_i(rdata),
      .idle_o(idle), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic r, input logic [1:0] t,
                           input logic [55:0] a, input logic [1:0] ty);
      req[p]            = r;
      tid[p*TW +: TW]   = t;
      addr[p*AW +: AW]  = a;
      wdata[p*DW +: DW] = 64'hCAFE_0000_0000_0000 | {8'h00, a};
      rtype[p*2 +: 2]   = ty;
   endtask

   task automatic ret(input logic v, input logic [3:0] tg, input logic [127:0] d);
      rv    = v;
      rtag  = tg;
      rdata = d;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0] t [3];
      logic [3:0] prev_tag;
      logic [1:0] prev_port;

      rst = 1'b1; req = '0; addr = '0; wdata = '0; rtype = '0; tid = '0;
      gnt = 1'b0; rv = 1'b0; rtag = '0; rdata = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      // ---------------- reset state ----------------
      chk("rst_ack",      128'(ack),      128'(0));
      chk("rst_mem_req",  128'(mem_req),  128'(0));
      chk("rst_mem_tag",  128'(mem_tag),  128'(0));
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_rtrn_vld", 128'(rtrn_vld), 128'(0));
      chk("rst_rtrn_data",128'(rtrn_data),128'(0));
      chk("rst_idle",     128'(idle),     128'(1));
      chk("rst_err",      128'(err),      128'(0));
      tick();

      // ---------------- single request and return ----------------
      set_port(1, 1'b1, 2'd2, 56'h8000_1000, 2'd0);
      gnt = 1'b1;
      #1;
      chk("t1_ack", 128'(ack), 128'(3'b010));
      tick();
      set_port(1, 1'b0, 2'd0, 56'h0, 2'd0);
      chk("t1_mem_req",  128'(mem_req),  128'(1));
      chk("t1_mem_addr", 128'(mem_addr), 128'(56'h8000_1000));
      chk("t1_mem_tag",  128'(mem_tag),  128'(4'b0110));
      chk("t1_mem_type", 128'(mem_type), 128'(0));
      chk("t1_busy_idle",128'(idle),     128'(0));
      ret(1'b1, 4'h6, 128'hDEAD_BEEF);
      tick();
      ret(1'b0, 4'h0, 128'h0);
      chk("t1_rtrn_vld",  128'(rtrn_vld),  128'(3'b010));
      chk("t1_rtrn_tid",  128'(rtrn_tid),  128'(2));
      chk("t1_rtrn_data", 128'(rtrn_data), 128'hDEAD_BEEF);
      chk("t1_idle",      128'(idle),      128'(1));
      tick();
      chk("t1_rtrn_vld_off", 128'(rtrn_vld), 128'(0));

      // ---------------- round robin, full throughput ----------------
      pulse_reset();
      t[0] = 2'd0; t[1] = 2'd1; t[2] = 2'd2;
      prev_tag = '0; prev_port = '0;
      for (int k = 0; k < 7; k++) begin
         for (int p = 0; p < 3; p++) begin
            set_port(p, (k < 6), t[p], 56'(32'h100 * (p + 1) + k), 2'd0);
         end
         if (k > 0) ret(1'b1, prev_tag, 128'(k));
         else       ret(1'b0, 4'h0, 128'h0);
         #1;
         if (k < 6) chk("rr_ack", 128'(ack), 128'(3'b001 << (k % 3)));
         else       chk("rr_ack_none", 128'(ack), 128'(0));
         if (k > 0) begin
            chk("rr_mem_req", 128'(mem_req), 128'(1));
            chk("rr_mem_tag", 128'(mem_tag), 128'(prev_tag));
         end
         if (k > 1) chk("rr_rtrn_vld", 128'(rtrn_vld), 128'(3'b001 << ((k - 2) % 3)));
         if (k < 6) begin
            prev_port    = 2'(k % 3);
            prev_tag     = {prev_port, t[k % 3]};
            t[k % 3]     = t[k % 3] + 2'd1;
         end
         tick();
      end
      ret(1'b0, 4'h0, 128'h0);
      tick(); tick();
      chk("rr_idle", 128'(idle), 128'(1));

      // ---------------- grant stall, then outstanding limit ----------------
      set_port(0, 1'b1, 2'd0, 56'h1234, 2'd1);
      gnt = 1'b0;
      #1;
      chk("st_ack0", 128'(ack), 128'(3'b001));
      tick();
      set_port(0, 1'b1, 2'd1, 56'h5678, 2'd1);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("st_no_ack",  128'(ack),       128'(0));
         chk("st_req",     128'(mem_req),   128'(1));
         chk("st_addr",    128'(mem_addr),  128'(56'h1234));
         chk("st_tag",     128'(mem_tag),   128'(4'b0000));
         chk("st_wdata",   128'(mem_wdata), 128'(64'hCAFE_0000_0000_1234));
         tick();
      end
      gnt = 1'b1;
      #1;
      chk("st_ack_on_gnt", 128'(ack), 128'(3'b001));
      tick();
      set_port(0, 1'b1, 2'd2, 56'h9ABC, 2'd0);
      chk("st_tag2",  128'(mem_tag),  128'(4'b0001));
      chk("st_addr2", 128'(mem_addr), 128'(56'h5678));
      #1;
      chk("lim_stall_a", 128'(ack), 128'(0));
      tick();
      #1;
      chk("lim_stall_b", 128'(ack), 128'(0));
      chk("lim_mem_empty", 128'(mem_req), 128'(0));
      ret(1'b1, 4'h0, 128'h55);
      #1;
      chk("lim_no_bypass", 128'(ack), 128'(0));
      tick();
      ret(1'b0, 4'h0, 128'h0);
      #1;
      chk("lim_ack_after_rtrn", 128'(ack),      128'(3'b001));
      chk("lim_rtrn_vld",       128'(rtrn_vld), 128'(3'b001));
      tick();
      set_port(0, 1'b0, 2'd0, 56'h0, 2'd0);
      chk("lim_tag3", 128'(mem_tag), 128'(4'b0010));
      ret(1'b1, 4'h1, 128'h1);
      tick();
      ret(1'b1, 4'h2, 128'h2);
      tick();
      ret(1'b0, 4'h0, 128'h0);
      tick();
      chk("lim_idle", 128'(idle), 128'(1));
      chk("lim_err",  128'(err),  128'(0));

      // ---------------- busy tid blocks only its own port ----------------
      set_port(2, 1'b1, 2'd1, 56'hA000, 2'd0);
      #1;
      chk("bz_ack_p2", 128'(ack), 128'(3'b100));
      tick();
      set_port(1, 1'b1, 2'd0, 56'hB000, 2'd0);
      #1;
      chk("bz_ack_p1",  128'(ack),     128'(3'b010));
      chk("bz_mem_tag", 128'(mem_tag), 128'(4'b1001));
      tick();
      set_port(1, 1'b0, 2'd0, 56'h0, 2'd0);
      ret(1'b1, 4'b1001, 128'hA5);
      #1;
      chk("bz_still_blocked", 128'(ack), 128'(0));
      tick();
      ret(1'b0, 4'h0, 128'h0);
      #1;
      chk("bz_ack_after_rtrn", 128'(ack),      128'(3'b100));
      chk("bz_rtrn_vld",       128'(rtrn_vld), 128'(3'b100));
      chk("bz_rtrn_tid",       128'(rtrn_tid), 128'(1));
      tick();
      set_port(2, 1'b0, 2'd0, 56'h0, 2'd0);
      tick(); tick();
      // in flight now: port1 tid0 (0x4), port2 tid1 (0x9)

      // ---------------- stray return ----------------
      ret(1'b1, 4'h3, 128'hBAD);
      tick();
      ret(1'b0, 4'h0, 128'h0);
      chk("er_err",      128'(err),      128'(1));
      chk("er_rtrn_vld", 128'(rtrn_vld), 128'(0));
      tick();
      chk("er_sticky",   128'(err),      128'(1));
      chk("er_not_idle", 128'(idle),     128'(0));

      // ---------------- reset mid-operation ----------------
      set_port(2, 1'b1, 2'd3, 56'hC000, 2'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_ack",     128'(ack),       128'(0));
      chk("ar_mem_req", 128'(mem_req),   128'(0));
      chk("ar_mem_tag", 128'(mem_tag),   128'(0));
      chk("ar_rtrn_d",  128'(rtrn_data), 128'(0));
      chk("ar_err",     128'(err),       128'(0));
      chk("ar_idle",    128'(idle),      128'(1));
      set_port(2, 1'b0, 2'd0, 56'h0, 2'd0);
      tick();
      rst = 1'b0;
      tick();
      ret(1'b1, 4'h9, 128'h9);
      tick();
      ret(1'b0, 4'h0, 128'h0);
      chk("ar_stale9_err",  128'(err),      128'(1));
      chk("ar_stale9_vld",  128'(rtrn_vld), 128'(0));
      pulse_reset();
      chk("ar_err_clr", 128'(err), 128'(0));
      ret(1'b1, 4'h4, 128'h4);
      tick();
      ret(1'b0, 4'h0, 128'h0);
      chk("ar_stale4_err", 128'(err),      128'(1));
      chk("ar_stale4_vld", 128'(rtrn_vld), 128'(0));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
